// File: rtl/matrix_window_ctrl_1bit.sv
// Frame/line sequencer for the 1-bit 3x3 morphology path: tracks pixel position,
// qualifies full-window pixels and reports frame boundaries and geometry errors.
module matrix_window_ctrl_1bit #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          matrix_frame_vsync,
    input  logic          matrix_frame_hsync,
    input  logic          matrix_frame_valid,
    output logic          win_valid,
    output logic          win_border,
    output logic [CW-1:0] win_cx,
    output logic [CW-1:0] win_cy,
    output logic          frame_start,
    output logic          frame_done,
    output logic          line_len_err,
    output logic          frame_len_err
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        CLOSING
    } state_t;

    localparam logic [CW-1:0] IMG_W_C = CW'(IMG_W);
    localparam logic [CW-1:0] IMG_H_C = CW'(IMG_H);
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        state;
    logic          vsync_d;
    logic          hsync_d;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic [CW-1:0] row_nxt;
    logic          vs_rise;
    logic          vs_fall;
    logic          hs_fall;
    logic          pix;
    logic          line_had_pix;
    logic          win_ok;

    always_comb begin
        vs_rise      = matrix_frame_vsync & ~vsync_d;
        vs_fall      = ~matrix_frame_vsync & vsync_d;
        hs_fall      = ~matrix_frame_hsync & hsync_d;
        pix          = matrix_frame_valid & matrix_frame_hsync & (state == ACTIVE);
        line_had_pix = (col != '0);
        win_ok       = (col >= CW'(2)) && (row >= CW'(2)) && (col < IMG_W_C);
        row_nxt      = row;
        if (hs_fall && line_had_pix && (row != CNT_MAX)) begin
            row_nxt = row + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            vsync_d       <= 1'b0;
            hsync_d       <= 1'b0;
            col           <= '0;
            row           <= '0;
            win_valid     <= 1'b0;
            win_border    <= 1'b0;
            win_cx        <= '0;
            win_cy        <= '0;
            frame_start   <= 1'b0;
            frame_done    <= 1'b0;
            line_len_err  <= 1'b0;
            frame_len_err <= 1'b0;
        end else begin
            vsync_d     <= matrix_frame_vsync;
            hsync_d     <= matrix_frame_hsync;
            frame_start <= vs_rise;
            frame_done  <= 1'b0;
            win_valid   <= pix & win_ok;
            win_border  <= pix & ~win_ok;
            if (pix && win_ok) begin
                win_cx <= col - CW'(1);
                win_cy <= row - CW'(1);
            end

            if (vs_rise) begin
                state         <= ACTIVE;
                col           <= '0;
                row           <= '0;
                line_len_err  <= 1'b0;
                frame_len_err <= 1'b0;
            end else begin
                case (state)
                    ACTIVE: begin
                        if (hs_fall) begin
                            col <= '0;
                        end else if (pix && (col != CNT_MAX)) begin
                            col <= col + CW'(1);
                        end
                        row <= row_nxt;
                        if (hs_fall && line_had_pix && (col != IMG_W_C)) begin
                            line_len_err <= 1'b1;
                        end
                        if (vs_fall) begin
                            state <= CLOSING;
                        end
                    end
                    // Frame end is confirmed one cycle after vsync falls so that a
                    // one-cycle vsync glitch resynchronises without a frame_done.
                    // row already holds the post-hs_fall count from the fall cycle.
                    CLOSING: begin
                        state         <= IDLE;
                        frame_done    <= 1'b1;
                        frame_len_err <= (row != IMG_H_C);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
